// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for the sequential InvSubBytes engine: input state plus
// ready/valid, and the registered result with its own ready/valid.
interface inv_sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: substitutes LANES bytes per cycle of a captured
// 128-bit state and presents the complete result on a held ready/valid output.
module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    inv_sub_bytes_seq_if.slave  bus
);
    localparam int unsigned GROUPS = 16 / LANES;
    localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(GROUPS - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : gBadLanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsmState_t;

    fsmState_t    state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [127:0] work, workNext;
    logic [127:0] stateOut, stateOutNext;
    logic         outValid, outValidNext;
    logic [127:0] subbed;
    int unsigned  groupBase;

    // Only the current group of LANES bytes is substituted; others pass through.
    always_comb begin
        groupBase = 32'(cnt) * LANES;
        subbed    = work;
        for (int unsigned l = 0; l < LANES; l++) begin
            subbed[(groupBase + l) * 8 +: 8] = INV_SBOX[work[(groupBase + l) * 8 +: 8]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            stateOut <= '0;
            outValid <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            work     <= workNext;
            stateOut <= stateOutNext;
            outValid <= outValidNext;
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        workNext     = work;
        stateOutNext = stateOut;
        outValidNext = outValid;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    workNext  = bus.state_in;
                    cntNext   = '0;
                    stateNext = RUN;
                end
            end
            RUN: begin
                workNext = subbed;
                cntNext  = cnt + 1'b1;
                if (cnt == LAST_CNT) begin
                    cntNext      = '0;
                    stateOutNext = subbed;
                    outValidNext = 1'b1;
                    stateNext    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    outValidNext = 1'b0;
                    stateNext    = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = outValid;
    assign bus.state_out = stateOut;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: vector table, GF(2^8)-derived model
// for round-trip/exhaustive sweeps, latency at LANES=1/4/16, backpressure, reset.
module tb_inv_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic [127:0] stateIn;
    logic         outReady;

    always #5 clk = ~clk;

    inv_sub_bytes_seq_if bus4 ();
    inv_sub_bytes_seq_if bus1 ();
    inv_sub_bytes_seq_if bus16 ();

    assign bus4.in_valid   = inValid;
    assign bus4.state_in   = stateIn;
    assign bus4.out_ready  = outReady;
    assign bus1.in_valid   = inValid;
    assign bus1.state_in   = stateIn;
    assign bus1.out_ready  = outReady;
    assign bus16.in_valid  = inValid;
    assign bus16.state_in  = stateIn;
    assign bus16.out_ready = outReady;

    inv_sub_bytes_seq #(.LANES(4))  dut   (.clk(clk), .rst(rst), .bus(bus4));
    inv_sub_bytes_seq #(.LANES(1))  dutL1 (.clk(clk), .rst(rst), .bus(bus1));
    inv_sub_bytes_seq #(.LANES(16)) dutL16 (.clk(clk), .rst(rst), .bus(bus16));

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] fwdBox [256];
    logic [7:0] invBox [256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sboxCalc(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] modelInv(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = invBox[s[i*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] modelFwd(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = fwdBox[s[i*8 +: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the LANES=4 instance; latency counted from accept edge.
    task automatic doTxn(input logic [127:0] s, output logic [127:0] res, output int lat);
        int n = 0;
        inValid = 1'b1;
        stateIn = s;
        while (!bus4.in_ready && n < 50) begin tick(); n++; end
        tick();
        inValid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 50) begin tick(); lat++; end
        res = bus4.state_out;
        if (lat >= 50) check("txn_timeout", 128'(lat), 128'd4);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] res, expA, r, s, e;
        int lat, lat1, lat4, lat16;

        vecs[0] = '{128'h63636363636363636363636363636363, 128'h00000000000000000000000000000000};
        vecs[1] = '{128'h00000000000000000000000000000000, 128'h52525252525252525252525252525252};
        vecs[2] = '{128'h638293c31bfc33f5c4eeacea4bc12816, 128'h00112233445566778899aabbccddeeff};
        vecs[3] = '{128'h16161616161616161616161616161616, 128'hffffffffffffffffffffffffffffffff};
        vecs[4] = '{128'hedededededededededededededededed, 128'h53535353535353535353535353535353};
        vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};

        for (int x = 0; x < 256; x++) fwdBox[x] = sboxCalc(8'(x));
        for (int x = 0; x < 256; x++) invBox[fwdBox[x]] = 8'(x);

        rst = 1'b1; inValid = 1'b0; outReady = 1'b0; stateIn = '0;
        repeat (3) tick();
        check("rst_out_valid", 128'(bus4.out_valid), 128'd0);
        check("rst_state_out", bus4.state_out, 128'd0);
        check("rst_in_ready", 128'(bus4.in_ready), 128'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(bus4.in_ready), 128'd1);
        tick();

        // Latency on three lane counts, accepted together.
        inValid = 1'b1;
        stateIn = vecs[2].din;
        tick();
        inValid = 1'b0;
        lat1 = 0; lat4 = 0; lat16 = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus1.out_valid && lat1 == 0) lat1 = c;
            if (bus4.out_valid && lat4 == 0) lat4 = c;
            if (bus16.out_valid && lat16 == 0) lat16 = c;
            check("busy_in_ready", {125'd0, bus1.in_ready, bus4.in_ready, bus16.in_ready}, 128'd0);
        end
        check("lat_lanes1", 128'(lat1), 128'd16);
        check("lat_lanes4", 128'(lat4), 128'd4);
        check("lat_lanes16", 128'(lat16), 128'd1);
        check("res_lanes1", bus1.state_out, vecs[2].dout);
        check("res_lanes16", bus16.state_out, vecs[2].dout);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;

        for (int i = 0; i < 6; i++) begin
            doTxn(vecs[i].din, res, lat);
            check($sformatf("vec%0d", i), res, vecs[i].dout);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'd4);
        end

        for (int i = 0; i < 50; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            doTxn(modelFwd(r), res, lat);
            check($sformatf("roundtrip%0d", i), res, r);
        end

        // Every byte value reaches every position across the sweep.
        for (int v = 0; v < 256; v++) begin
            for (int i = 0; i < 16; i++) s[i*8 +: 8] = 8'(v + i);
            e = modelInv(s);
            doTxn(s, res, lat);
            check($sformatf("sweep%0d", v), res, e);
        end

        // Backpressure: second request held during DONE.
        expA = vecs[2].dout;
        inValid = 1'b1;
        stateIn = vecs[2].din;
        tick();
        stateIn = vecs[1].din;
        lat = 0;
        while (!bus4.out_valid && lat < 50) begin tick(); lat++; end
        check("bp_first_lat", 128'(lat), 128'd4);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", 128'(bus4.out_valid), 128'd1);
            check("bp_hold_data", bus4.state_out, expA);
            check("bp_hold_in_ready", 128'(bus4.in_ready), 128'd0);
            tick();
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        check("bp_release_valid", 128'(bus4.out_valid), 128'd0);
        check("bp_release_in_ready", 128'(bus4.in_ready), 128'd1);
        check("bp_release_data", bus4.state_out, expA);
        tick();
        inValid = 1'b0;
        check("bp_second_accepted", 128'(bus4.in_ready), 128'd0);
        lat = 0;
        while (!bus4.out_valid && lat < 50) begin tick(); lat++; end
        check("bp_second_lat", 128'(lat), 128'd4);
        check("bp_second_data", bus4.state_out, vecs[1].dout);
        outReady = 1'b1;
        tick();

        // out_ready with nothing pending.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready_valid", 128'(bus4.out_valid), 128'd0);
            check("idle_ready_data", bus4.state_out, vecs[1].dout);
        end
        outReady = 1'b0;

        // Reset on the second RUN cycle.
        inValid = 1'b1;
        stateIn = vecs[0].din;
        tick();
        inValid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("midrun_rst_valid", 128'(bus4.out_valid), 128'd0);
        check("midrun_rst_data", bus4.state_out, 128'd0);
        check("midrun_rst_in_ready", 128'(bus4.in_ready), 128'd0);
        rst = 1'b0;
        #1;
        check("midrun_after_in_ready", 128'(bus4.in_ready), 128'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrun_no_result", 128'(bus4.out_valid), 128'd0);
        end

        // Reset while holding a result in DONE.
        inValid = 1'b1;
        stateIn = vecs[4].din;
        tick();
        inValid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 50) begin tick(); lat++; end
        check("done_rst_pre_data", bus4.state_out, vecs[4].dout);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("done_rst_valid", 128'(bus4.out_valid), 128'd0);
        check("done_rst_data", bus4.state_out, 128'd0);
        tick();
        check("done_rst_in_ready", 128'(bus4.in_ready), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
